// File: rtl/carry_normalize_serial_if.sv
// Operand/result handshake bundle for carry_normalize_serial.
// master drives operands and out_ready; slave is the normalizer itself.
interface carry_normalize_serial_if #(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int WORD_LEN     = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [BIT_LEN-1:0]  A [NUM_ELEMENTS];
  logic [WORD_LEN-1:0] M [NUM_ELEMENTS];
  logic                out_valid;
  logic                out_ready;
  logic [BIT_LEN-1:0]  R [NUM_ELEMENTS];
  logic                ovf;

  modport master (
    output in_valid, A, M, out_ready,
    input  in_ready, out_valid, R, ovf
  );

  modport slave (
    input  in_valid, A, M, out_ready,
    output in_ready, out_valid, R, ovf
  );
endinterface

// File: rtl/carry_normalize_serial.sv
// Serial carry normalizer: folds redundant limbs into canonical words one
// word per clock, subtracting the modulus alongside, then picks X or X-M.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | propagating carry/borrow through word k
// DONE  | result held until the consumer takes it
module carry_normalize_serial #(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int WORD_LEN     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  carry_normalize_serial_if.slave bus
);

  localparam int KW = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_ELEMENTS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [KW-1:0]       k;
  logic [1:0]          c;
  logic                b;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                ovf_q;
  logic [BIT_LEN-1:0]  r_q  [NUM_ELEMENTS];
  logic [BIT_LEN-1:0]  a_q  [NUM_ELEMENTS];
  logic [WORD_LEN-1:0] m_q  [NUM_ELEMENTS];
  logic [WORD_LEN-1:0] x_q  [NUM_ELEMENTS];
  logic [WORD_LEN-1:0] d_q  [NUM_ELEMENTS];

  // Per-word datapath; s is one bit wider than a limb so c (max 2) never truncates.
  logic [BIT_LEN:0]    s;
  logic [WORD_LEN:0]   diff;
  logic [WORD_LEN-1:0] x_new;
  logic [WORD_LEN-1:0] d_new;
  logic [1:0]          c_new;
  logic                b_new;
  logic                take_d;
  logic                ovf_new;
  logic [BIT_LEN-1:0]  r_x [NUM_ELEMENTS];
  logic [BIT_LEN-1:0]  r_d [NUM_ELEMENTS];

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.R         = r_q;

  // Carry add and modulus subtract for the current word.
  always_comb begin
    s       = {1'b0, a_q[k]} + {{(BIT_LEN-1){1'b0}}, c};
    x_new   = s[WORD_LEN-1:0];
    c_new   = s[WORD_LEN+1:WORD_LEN];
    diff    = {1'b0, x_new} - {1'b0, m_q[k]} - {{WORD_LEN{1'b0}}, b};
    d_new   = diff[WORD_LEN-1:0];
    b_new   = diff[WORD_LEN];
    // X - M = (c - b) * 2^(WORD_LEN*N) + D, so the sign lives in c versus b.
    take_d  = (c_new >= {1'b0, b_new});
    ovf_new = (c_new >  {1'b0, b_new});
  end

  // Candidate results; the top word is still in flight on the final edge.
  always_comb begin
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      r_x[i] = BIT_LEN'(x_q[i]);
      r_d[i] = BIT_LEN'(d_q[i]);
    end
    r_x[NUM_ELEMENTS-1] = BIT_LEN'(x_new);
    r_d[NUM_ELEMENTS-1] = BIT_LEN'(d_new);
  end

  // Control FSM with registered handshake outputs and result words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      k           <= '0;
      c           <= '0;
      b           <= 1'b0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        r_q[i] <= '0;
        a_q[i] <= '0;
        m_q[i] <= '0;
        x_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.A;
            m_q        <= bus.M;
            k          <= '0;
            c          <= '0;
            b          <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          x_q[k] <= x_new;
          d_q[k] <= d_new;
          c      <= c_new;
          b      <= b_new;
          k      <= k + 1'b1;
          if (k == K_LAST) begin
            out_valid_q <= 1'b1;
            ovf_q       <= ovf_new;
            r_q         <= take_d ? r_d : r_x;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carry_normalize_serial.sv
// Bench for carry_normalize_serial: directed corner cases plus random operands
// against a big-integer reference of X and M.
module tb_carry_normalize_serial;
  localparam int N  = 17;
  localparam int BL = 17;
  localparam int WL = 16;
  localparam int BW = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  carry_normalize_serial_if #(.NUM_ELEMENTS(N), .BIT_LEN(BL), .WORD_LEN(WL)) bus ();

  carry_normalize_serial #(.NUM_ELEMENTS(N), .BIT_LEN(BL), .WORD_LEN(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [BL-1:0]   cur_a [N];
  logic [WL-1:0]   cur_m [N];
  logic [N*BL-1:0] exp_r;
  logic            exp_ovf;

  task automatic check(input string tag, input logic [N*BL-1:0] obs, input logic [N*BL-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N*BL-1:0] dut_r();
    logic [N*BL-1:0] v;
    for (int i = 0; i < N; i++) v[i*BL +: BL] = bus.R[i];
    return v;
  endfunction

  // Reference: whole-number X and M, one conditional subtraction.
  task automatic model();
    logic [BW-1:0] x, m, d, v;
    x = '0;
    m = '0;
    for (int i = 0; i < N; i++) begin
      x = x + (BW'(cur_a[i]) << (WL * i));
      m = m + (BW'(cur_m[i]) << (WL * i));
    end
    if (x >= m) begin
      d       = x - m;
      v       = d;
      exp_ovf = (d >> (WL * N)) != '0;
    end else begin
      v       = x;
      exp_ovf = 1'b0;
    end
    for (int i = 0; i < N; i++) exp_r[i*BL +: BL] = {1'b0, v[i*WL +: WL]};
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      bus.A[i] = BL'($urandom);
      bus.M[i] = WL'($urandom);
    end
  endtask

  task automatic accept_op();
    for (int i = 0; i < N; i++) begin
      bus.A[i] = cur_a[i];
      bus.M[i] = cur_m[i];
    end
    check("in_ready_idle", N*BL'(bus.in_ready), N*BL'(1));
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    check("in_ready_busy", N*BL'(bus.in_ready), N*BL'(0));
  endtask

  task automatic run_op(input string tag, input int hold);
    int cyc;
    logic [N*BL-1:0] r0;
    model();
    accept_op();
    bus.in_valid = 1'b1;
    cyc = 0;
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.in_valid = 1'b1;
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, N*BL'(cyc), N*BL'(N));
    check({tag, "_R"}, dut_r(), exp_r);
    check({tag, "_ovf"}, N*BL'(bus.ovf), N*BL'(exp_ovf));
    r0 = dut_r();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_R"}, dut_r(), exp_r);
      check({tag, "_hold_ovf"}, N*BL'(bus.ovf), N*BL'(exp_ovf));
      check({tag, "_hold_valid"}, N*BL'(bus.out_valid), N*BL'(1));
      check({tag, "_hold_in_ready"}, N*BL'(bus.in_ready), N*BL'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_release_valid"}, N*BL'(bus.out_valid), N*BL'(0));
    check({tag, "_release_in_ready"}, N*BL'(bus.in_ready), N*BL'(1));
    check({tag, "_R_kept"}, dut_r(), r0);
  endtask

  task automatic clear_op();
    for (int i = 0; i < N; i++) begin
      cur_a[i] = '0;
      cur_m[i] = '0;
    end
  endtask

  task automatic set_carry_case();
    clear_op();
    cur_a[0]  = 17'h1FFFF;
    cur_m[16] = 16'h8000;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    #12;
    check("rst_in_ready", N*BL'(bus.in_ready), N*BL'(1));
    check("rst_out_valid", N*BL'(bus.out_valid), N*BL'(0));
    check("rst_ovf", N*BL'(bus.ovf), N*BL'(0));
    check("rst_R", dut_r(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    clear_op();
    cur_m[0] = 16'h0001;
    run_op("zero", 0);

    set_carry_case();
    run_op("carry", 0);

    for (int i = 0; i < N; i++) begin
      cur_a[i] = 17'h01234;
      cur_m[i] = 16'h1234;
    end
    run_op("x_eq_m", 0);

    clear_op();
    cur_a[16] = 17'h1FFFF;
    cur_m[0]  = 16'h0001;
    run_op("overflow", 0);

    set_carry_case();
    run_op("stall", 5);

    // Abort mid-RUN with k = 8 pending, then a clean operand.
    for (int i = 0; i < N; i++) begin
      cur_a[i] = BL'($urandom);
      cur_m[i] = WL'($urandom);
    end
    accept_op();
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", N*BL'(bus.out_valid), N*BL'(0));
    check("abort_R", dut_r(), '0);
    check("abort_ovf", N*BL'(bus.ovf), N*BL'(0));
    check("abort_in_ready", N*BL'(bus.in_ready), N*BL'(1));
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_carry_case();
    run_op("after_abort", 0);

    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < N; i++) begin
        cur_m[i] = WL'($urandom);
        if (t % 2 == 0) cur_a[i] = BL'($urandom);
        else            cur_a[i] = BL'(cur_m[i]) + BL'($urandom_range(0, 1));
      end
      if (t % 4 == 1) cur_a[16] = BL'(cur_m[16]) - 1'b1;
      run_op("random", t % 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
